// File: rtl/cs_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cs_seq_pkg
//  Description : Shared types, error codes and helpers for the cs command
//                sequencer.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package cs_seq_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SEL   = 3'd2,
        S_START = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_ACK   = 3'd6
    } state_t;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TMO   = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;
    localparam logic [1:0] ERR_FULL  = 2'd3;

    // Width of a stage index; at least one bit even for a single stage
    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cs_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cs_seq_if
//  Description : Upstream / downstream handshake bundle of the cs command
//                sequencer. The sequencer uses the slave view; the environment
//                driving it (upstream receiver plus stages) uses the master view.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
interface cs_seq_if #(
    parameter int NSTG  = 3,
    parameter int NFIFO = 3
);
    import cs_seq_pkg::*;

    localparam int SW = sw_of(NSTG);

    logic             fs_in;
    logic             fd_in;
    logic [NSTG-1:0]  fs_stg;
    logic [NSTG-1:0]  fd_stg;
    logic [NSTG-1:0]  stg_en;
    logic [NFIFO-1:0] fifo_full;
    logic             err_in;
    logic             busy;
    logic             err;
    logic [1:0]       err_code;
    logic [SW-1:0]    err_stg;
    logic [15:0]      txn_cnt;

    modport master (
        output fs_in, fd_stg, stg_en, fifo_full, err_in,
        input  fd_in, fs_stg, busy, err, err_code, err_stg, txn_cnt
    );

    modport slave (
        input  fs_in, fd_stg, stg_en, fifo_full, err_in,
        output fd_in, fs_stg, busy, err, err_code, err_stg, txn_cnt
    );

endinterface
`default_nettype wire

// File: rtl/cs_seq_tmo.sv
`default_nettype none
// ============================================================================
//  Module      : cs_seq_tmo
//  Description : Per-phase timeout counter. Clear restarts the count for the
//                cycle it is asserted in, enable counts the current cycle, and
//                the count saturates at all-ones. hit_o flags the cycle in which
//                the count (including that cycle) reaches TMO_MAX; TMO_MAX of
//                zero disables the timeout.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module cs_seq_tmo #(
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      hit_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] base_d;
    logic [TMO_W-1:0] cnt_d;

    // A clear in this cycle means the phase just started: count from zero
    assign base_d = clr_i ? '0 : cnt_q;
    assign cnt_d  = (&base_d) ? base_d : base_d + TMO_W'(1);
    assign hit_o  = en_i && (TMO_MAX != '0) && (cnt_d == TMO_MAX);

    // Count enabled cycles since the last clear, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end else if (clr_i) begin
            cnt_q <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cs_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cs_seq
//  Description : Parametrised command sequencer. On a rising upstream start
//                flag it runs a four-phase fs/fd handshake with every enabled
//                downstream stage in index order, with FIFO-full gating,
//                per-phase timeout and external abort, then acknowledges
//                upstream. Errors are reported and always end in a completion.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module cs_seq
    import cs_seq_pkg::*;
#(
    parameter int               NSTG    = 3,
    parameter int               NFIFO   = 3,
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}}
) (
    input  wire logic clk,
    input  wire logic rst,
    cs_seq_if.slave   bus
);

    localparam int            SW     = sw_of(NSTG);
    localparam logic [SW-1:0] K_LAST = SW'(NSTG - 1);

    state_t          state_q;
    logic [SW-1:0]   k_q;
    logic [SW-1:0]   k_d;
    logic [NSTG-1:0] en_l_q;
    logic [NSTG-1:0] fs_stg_q;
    logic [NSTG-1:0] sel_d;
    logic            fs_in_d_q;
    logic            fd_in_q;
    logic            busy_q;
    logic            err_q;
    logic [1:0]      err_code_q;
    logic [SW-1:0]   err_stg_q;
    logic [15:0]     txn_cnt_q;
    logic [15:0]     txn_cnt_d;
    logic            tmo_clr_q;

    logic            w_cur_fd;
    logic            w_progress;
    logic            w_tmo_en;
    logic            w_tmo_hit;
    logic            w_abort;
    logic            w_tmo_err;

    assign k_d       = k_q + SW'(1);
    assign sel_d     = NSTG'(1) << k_q;
    assign txn_cnt_d = txn_cnt_q + 16'd1;
    assign w_cur_fd  = bus.fd_stg[k_q];

    assign w_tmo_en  = (state_q == S_WAIT) || (state_q == S_START) || (state_q == S_DONE);
    assign w_abort   = bus.err_in && ((state_q == S_WAIT) || (state_q == S_SEL) ||
                                      (state_q == S_START) || (state_q == S_DONE));
    // The awaited event in a waiting phase wins over a timeout in the same cycle
    assign w_tmo_err = w_tmo_hit && !w_progress;

    // Awaited event of each waiting phase
    always_comb begin
        w_progress = 1'b0;
        case (state_q)
            S_WAIT:  w_progress = ~|bus.fifo_full;
            S_START: w_progress = w_cur_fd;
            S_DONE:  w_progress = ~w_cur_fd;
            default: w_progress = 1'b0;
        endcase
    end

    cs_seq_tmo #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmo_clr_q),
        .en_i  (w_tmo_en),
        .hit_o (w_tmo_hit)
    );

    // Sequencer FSM with registered outputs; tmo_clr_q marks the first cycle of each state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            en_l_q     <= '0;
            fs_stg_q   <= '0;
            // Treat fs_in as already high so a level held across reset is no start
            fs_in_d_q  <= 1'b1;
            fd_in_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_stg_q  <= '0;
            txn_cnt_q  <= '0;
            tmo_clr_q  <= 1'b0;
        end else begin
            fs_in_d_q <= bus.fs_in;
            tmo_clr_q <= 1'b0;
            if (w_abort || w_tmo_err) begin
                state_q    <= S_ERR;
                tmo_clr_q  <= 1'b1;
                fs_stg_q   <= '0;
                err_q      <= 1'b1;
                err_stg_q  <= k_q;
                err_code_q <= w_abort ? ERR_ABORT :
                              ((state_q == S_WAIT) ? ERR_FULL : ERR_TMO);
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.fs_in && !fs_in_d_q) begin
                            state_q    <= S_WAIT;
                            tmo_clr_q  <= 1'b1;
                            en_l_q     <= bus.stg_en;
                            err_q      <= 1'b0;
                            err_code_q <= ERR_NONE;
                            err_stg_q  <= '0;
                            k_q        <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (w_progress) begin
                            state_q   <= S_SEL;
                            tmo_clr_q <= 1'b1;
                        end
                    end
                    S_SEL: begin
                        if (en_l_q[k_q]) begin
                            state_q   <= S_START;
                            tmo_clr_q <= 1'b1;
                            fs_stg_q  <= sel_d;
                        end else if (k_q == K_LAST) begin
                            state_q   <= S_ACK;
                            tmo_clr_q <= 1'b1;
                            fd_in_q   <= 1'b1;
                            txn_cnt_q <= txn_cnt_d;
                        end else begin
                            k_q <= k_d;
                        end
                    end
                    S_START: begin
                        if (w_progress) begin
                            state_q   <= S_DONE;
                            tmo_clr_q <= 1'b1;
                            fs_stg_q  <= '0;
                        end
                    end
                    S_DONE: begin
                        if (w_progress) begin
                            tmo_clr_q <= 1'b1;
                            if (k_q == K_LAST) begin
                                state_q   <= S_ACK;
                                fd_in_q   <= 1'b1;
                                txn_cnt_q <= txn_cnt_d;
                            end else begin
                                state_q <= S_SEL;
                                k_q     <= k_d;
                            end
                        end
                    end
                    S_ERR: begin
                        // Let every stage finish its handshake before completing upstream
                        if (bus.fd_stg == '0) begin
                            state_q   <= S_ACK;
                            tmo_clr_q <= 1'b1;
                            fd_in_q   <= 1'b1;
                            txn_cnt_q <= txn_cnt_d;
                        end
                    end
                    S_ACK: begin
                        if (!bus.fs_in) begin
                            state_q   <= S_IDLE;
                            tmo_clr_q <= 1'b1;
                            fd_in_q   <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        fs_stg_q <= '0;
                        fd_in_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fs_stg   = fs_stg_q;
    assign bus.fd_in    = fd_in_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.err_stg  = err_stg_q;
    assign bus.txn_cnt  = txn_cnt_q;

endmodule
`default_nettype wire
